dct_mac_sequencer: RTL

//  Sequences one shared multiply-accumulate unit (macu) inside a DCT unit of the fdct_zigzag path.
//  Per start, it issues TAPS sample/coefficient taps to the macu and waits out the multiplier pipeline.
//  It then presents the finished accumulator result to the downstream zigzag/quantiser stage with a valid/ready handshake.

---
 rtl/dct_mac_sequencer_if.sv | 33 +++
 rtl/dct_mac_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dct_mac_sequencer_if.sv
// Handshake bundle between the DCT MAC sequencer and its macu/zigzag peers.
// master = sequencer side, slave = environment side.
interface dct_mac_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             start;
  logic             busy;
  logic [IDX_W-1:0] tap_idx;
  logic             mac_ena;
  logic             mac_clr;
  logic             acc_valid;
  logic             acc_ready;

  modport master (
    input  start,
    input  acc_ready,
    output busy,
    output tap_idx,
    output mac_ena,
    output mac_clr,
    output acc_valid
  );

  modport slave (
    output start,
    output acc_ready,
    input  busy,
    input  tap_idx,
    input  mac_ena,
    input  mac_clr,
    input  acc_valid
  );
endinterface

// File: rtl/dct_mac_sequencer.sv
// Sequences TAPS multiply-accumulate taps through one shared macu,
// waits out the multiplier pipeline, then hands the result downstream.
module dct_mac_sequencer #(
  parameter int TAPS     = 8,
  parameter int MULT_LAT = 2,
  parameter int IDX_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  dct_mac_sequencer_if.master bus
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [IDX_W-1:0] TAP_LAST =
    IDX_W'(TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((MULT_LAT > 0) ? (MULT_LAT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             issue_q, issue_d;
  logic             clr_q, clr_d;
  logic             valid_q, valid_d;

  // Next state: every transition is qualified by the global enable.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = ISSUE;
            tap_d   = '0;
          end
        end
        ISSUE: begin
          if (tap_q == TAP_LAST) begin
            tap_d = '0;
            if (MULT_LAT == 0) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else begin
            tap_d = tap_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            valid_d = 1'b0;
            if (bus.start) begin
              state_d = ISSUE;
              tap_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d  = (state_d != IDLE);
    issue_d = (state_d == ISSUE);
    clr_d   = issue_d && (tap_d == '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      issue_q <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      issue_q <= issue_d;
      clr_q   <= clr_d;
      valid_q <= valid_d;
    end
  end

  // A tap only counts in a cycle where the whole pipeline is enabled,
  // so the issue strobes are masked by ena; a stalled tap is re-presented.
  assign bus.mac_ena   = issue_q & ena;
  assign bus.mac_clr   = clr_q & ena;
  assign bus.busy      = busy_q;
  assign bus.tap_idx   = tap_q;
  assign bus.acc_valid = valid_q;

endmodule
